// File: rtl/mc_boot_loader.sv
`timescale 1ns/1ps
// Boot sequencer: streams a program image into instruction memory (optionally mirrored
// into data memory), then releases the cores from reset one at a time with a fixed stagger.
module mc_boot_loader #(
    parameter int                    NUM_CORES   = 2,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    MEM_WORDS   = 4096,
    parameter logic [ADDR_WIDTH-1:0] BOOT_BASE   = '0,
    parameter int                    RELEASE_GAP = 4,
    parameter bit                    MIRROR_DMEM = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_last,
    output logic                         imem_we,
    output logic                         dmem_we,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    output logic [NUM_CORES-1:0]         core_rst_n,
    output logic                         boot_done,
    output logic                         load_error,
    output logic [$clog2(MEM_WORDS):0]   word_count
);

    localparam int WC_W     = $clog2(MEM_WORDS) + 1;
    localparam int LAST_REL = (NUM_CORES - 1) * RELEASE_GAP;
    localparam int RC_W     = $clog2(LAST_REL + 2);

    typedef enum logic [2:0] {IDLE, LOAD, RELEASE, RUN, ERROR} state_t;

    state_t          state;
    state_t          next_state;
    logic [RC_W-1:0] rel_cnt;
    logic            accept;
    logic            overflow;
    logic            last_rel;
    logic            start_load;

    // Valid/ready: a word transfers on every cycle where s_valid && s_ready are both high;
    // s_ready is registered and only ever high while loading.
    assign accept     = s_valid && s_ready && (state == LOAD);
    assign overflow   = accept && !s_last && (word_count == WC_W'(MEM_WORDS - 1));
    assign last_rel   = (rel_cnt == RC_W'(LAST_REL));
    assign start_load = (state != LOAD) && (next_state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD: begin
                if (accept && s_last) next_state = RELEASE;
                else if (overflow)    next_state = ERROR;
            end
            RELEASE: if (last_rel) next_state = RUN;
            RUN:     if (start) next_state = LOAD;
            ERROR:   if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            dmem_we    <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            core_rst_n <= '0;
            boot_done  <= 1'b0;
            load_error <= 1'b0;
            word_count <= '0;
            rel_cnt    <= '0;
        end else begin
            s_ready <= (next_state == LOAD);
            imem_we <= accept;
            dmem_we <= MIRROR_DMEM & accept;
            if (accept) begin
                mem_wdata <= s_data;
                mem_addr  <= BOOT_BASE + (ADDR_WIDTH'(word_count) << 2);
            end

            if (start_load) begin
                word_count <= '0;
                load_error <= 1'b0;
                core_rst_n <= '0;
                boot_done  <= 1'b0;
            end else if (accept && (word_count != WC_W'(MEM_WORDS))) begin
                word_count <= word_count + 1'b1;
            end

            if (overflow) load_error <= 1'b1;

            // Counter is zero on the first RELEASE cycle, so core 0 always goes first.
            if (state == RELEASE) begin
                rel_cnt <= rel_cnt + 1'b1;
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (rel_cnt == RC_W'(i * RELEASE_GAP)) core_rst_n[i] <= 1'b1;
                end
                if (last_rel) boot_done <= 1'b1;
            end else begin
                rel_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mc_boot_loader.sv
`timescale 1ns/1ps
// Bench for mc_boot_loader: two instances (small memory at base 0 with dmem mirroring,
// and base 0x100 without mirroring) driven by scenario tasks against a word-level model.
module tb_mc_boot_loader;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [1:0]       start, s_valid, s_last, s_ready, imem_we, dmem_we, boot_done, load_error;
    logic [1:0][31:0] s_data, mem_addr, mem_wdata;
    logic [1:0][1:0]  core_rst_n;
    logic [2:0]       wc0;
    logic [4:0]       wc1;
    logic [1:0][7:0]  word_count;

    assign word_count[0] = {5'd0, wc0};
    assign word_count[1] = {3'd0, wc1};

    mc_boot_loader #(
        .NUM_CORES(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(4),
        .BOOT_BASE(32'h0), .RELEASE_GAP(4), .MIRROR_DMEM(1'b1)
    ) dut0 (
        .clk(clk), .rst(rst), .start(start[0]), .s_valid(s_valid[0]), .s_ready(s_ready[0]),
        .s_data(s_data[0]), .s_last(s_last[0]), .imem_we(imem_we[0]), .dmem_we(dmem_we[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .core_rst_n(core_rst_n[0]),
        .boot_done(boot_done[0]), .load_error(load_error[0]), .word_count(wc0)
    );

    mc_boot_loader #(
        .NUM_CORES(2), .DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_WORDS(16),
        .BOOT_BASE(32'h100), .RELEASE_GAP(2), .MIRROR_DMEM(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .start(start[1]), .s_valid(s_valid[1]), .s_ready(s_ready[1]),
        .s_data(s_data[1]), .s_last(s_last[1]), .imem_we(imem_we[1]), .dmem_we(dmem_we[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .core_rst_n(core_rst_n[1]),
        .boot_done(boot_done[1]), .load_error(load_error[1]), .word_count(wc1)
    );

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [1:0]  prev_acc = '0;
    logic [31:0] pkt[16];

    function automatic int mw(input int sel);
        return (sel == 0) ? 4 : 16;
    endfunction

    function automatic logic [31:0] base(input int sel);
        return (sel == 0) ? 32'h0 : 32'h100;
    endfunction

    function automatic int gap(input int sel);
        return (sel == 0) ? 4 : 2;
    endfunction

    // Negedge sample point: write-pulse timing, dmem mirroring and the write scoreboard.
    task automatic tick();
        logic [63:0] got;
        logic [63:0] exp;
        @(negedge clk);
        if (rst) begin
            prev_acc = '0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (imem_we[k] !== prev_acc[k]) begin
                    errors++;
                    $display("FAIL write_timing dut%0d imem_we=%b required %b", k, imem_we[k], prev_acc[k]);
                end
                checks++;
                if (dmem_we[k] !== ((k == 0) ? imem_we[k] : 1'b0)) begin
                    errors++;
                    $display("FAIL dmem_mirror dut%0d dmem_we=%b imem_we=%b", k, dmem_we[k], imem_we[k]);
                end
                if (imem_we[k] === 1'b1) begin
                    got = {mem_addr[k], mem_wdata[k]};
                    checks++;
                    if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
                        errors++;
                        $display("FAIL unexpected_write dut%0d addr=%h data=%h required none", k, got[63:32], got[31:0]);
                    end else begin
                        exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        if (got !== exp) begin
                            errors++;
                            $display("FAIL write dut%0d addr/data=%h/%h required %h/%h",
                                     k, got[63:32], got[31:0], exp[63:32], exp[31:0]);
                        end
                    end
                end
            end
            prev_acc = s_valid & s_ready;
        end
    endtask

    task automatic cycle();
        tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int sel);
        start[sel] = 1'b1;
        cycle();
        start[sel] = 1'b0;
    endtask

    task automatic push_word(input int sel, input logic [31:0] d, input bit last, input int maxw, output bit ok);
        s_valid[sel] = 1'b1;
        s_data[sel]  = d;
        s_last[sel]  = last;
        ok = 1'b0;
        for (int i = 0; i < maxw && !ok; i++) begin
            tick();
            if (s_ready[sel] === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        s_valid[sel] = 1'b0;
        s_last[sel]  = 1'b0;
    endtask

    // Model: a load keeps min(n, MEM_WORDS) words at base+4*i; it completes only when the
    // last flag arrives within capacity, and errors when capacity fills without it.
    task automatic run_load(input int sel, input int n, input bit last, input bit gaps,
                            output int got, output int exp_n, output bit exp_done, output bit exp_err);
        bit ok;
        exp_n    = (n < mw(sel)) ? n : mw(sel);
        exp_done = last && (n <= mw(sel));
        exp_err  = (n > mw(sel)) || (!last && n == mw(sel));
        for (int i = 0; i < exp_n; i++) begin
            if (sel == 0) exp_q0.push_back({base(sel) + 32'(4 * i), pkt[i]});
            else          exp_q1.push_back({base(sel) + 32'(4 * i), pkt[i]});
        end
        got = 0;
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(1, 2)) cycle();
            push_word(sel, pkt[i], last && (i == n - 1), 8, ok);
            if (!ok) break;
            got++;
        end
    endtask

    task automatic wait_release(input int sel, output int t0, output int t1);
        t0 = -1;
        t1 = -1;
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (t0 < 0 && core_rst_n[sel][0] === 1'b1) t0 = c;
            if (core_rst_n[sel][1] === 1'b1) begin
                t1 = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if ({s_ready[k], imem_we[k], dmem_we[k], boot_done[k], load_error[k]} !== 5'b0) begin
                errors++;
                $display("FAIL reset_flags dut%0d got %b required 00000", k,
                         {s_ready[k], imem_we[k], dmem_we[k], boot_done[k], load_error[k]});
            end
            checks++;
            if ({mem_addr[k], mem_wdata[k]} !== 64'h0) begin
                errors++;
                $display("FAIL reset_mem dut%0d got %h required 0", k, {mem_addr[k], mem_wdata[k]});
            end
            checks++;
            if (core_rst_n[k] !== 2'b00 || word_count[k] !== 8'd0) begin
                errors++;
                $display("FAIL reset_cores dut%0d core_rst_n=%b word_count=%0d required 00/0", k, core_rst_n[k], word_count[k]);
            end
        end
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (s_ready[k] !== 1'b0 || core_rst_n[k] !== 2'b00) begin
                errors++;
                $display("FAIL idle_after_reset dut%0d s_ready=%b core_rst_n=%b required 0/00", k, s_ready[k], core_rst_n[k]);
            end
        end
    endtask

    task automatic test_basic_load();
        int got, exp_n, t0, t1;
        bit done, err;
        pkt[0] = 32'h00000013;
        pkt[1] = 32'h00100093;
        pkt[2] = 32'h0000006F;
        pulse_start(0);
        run_load(0, 3, 1'b1, 1'b0, got, exp_n, done, err);
        checks++;
        if (got !== exp_n) begin
            errors++;
            $display("FAIL basic_accepts got %0d required %0d", got, exp_n);
        end
        wait_release(0, t0, t1);
        checks++;
        if (t0 < 0 || t1 - t0 != gap(0)) begin
            errors++;
            $display("FAIL basic_stagger core0 at %0d core1 at %0d required gap %0d", t0, t1, gap(0));
        end
        cycle();
        checks++;
        if (boot_done[0] !== done || load_error[0] !== err || word_count[0] !== 8'(exp_n)) begin
            errors++;
            $display("FAIL basic_status boot_done=%b load_error=%b word_count=%0d required %b/%b/%0d",
                     boot_done[0], load_error[0], word_count[0], done, err, exp_n);
        end
        checks++;
        if (exp_q0.size() != 0) begin
            errors++;
            $display("FAIL basic_writes missing %0d required 0", exp_q0.size());
        end
    endtask

    task automatic test_backpressure();
        int got, exp_n, t0, t1;
        bit done, err;
        for (int i = 0; i < 3; i++) pkt[i] = $urandom;
        pulse_start(0);
        checks++;
        if (core_rst_n[0] !== 2'b00 || boot_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_run core_rst_n=%b boot_done=%b required 00/0", core_rst_n[0], boot_done[0]);
        end
        run_load(0, 3, 1'b1, 1'b1, got, exp_n, done, err);
        checks++;
        if (got !== exp_n || word_count[0] !== 8'(exp_n)) begin
            errors++;
            $display("FAIL gap_accepts got %0d word_count=%0d required %0d", got, word_count[0], exp_n);
        end
        wait_release(0, t0, t1);
        cycle();
        checks++;
        if (exp_q0.size() != 0 || boot_done[0] !== done) begin
            errors++;
            $display("FAIL gap_writes missing %0d boot_done=%b required 0/%b", exp_q0.size(), boot_done[0], done);
        end
    endtask

    task automatic test_overflow();
        int got, exp_n;
        bit done, err;
        for (int i = 0; i < 5; i++) pkt[i] = $urandom;
        pulse_start(0);
        run_load(0, 5, 1'b0, 1'b0, got, exp_n, done, err);
        checks++;
        if (got !== exp_n) begin
            errors++;
            $display("FAIL overflow_accepts got %0d required %0d", got, exp_n);
        end
        repeat (3) cycle();
        checks++;
        if (load_error[0] !== err || s_ready[0] !== 1'b0 || boot_done[0] !== done) begin
            errors++;
            $display("FAIL overflow_status load_error=%b s_ready=%b boot_done=%b required %b/0/%b",
                     load_error[0], s_ready[0], boot_done[0], err, done);
        end
        checks++;
        if (core_rst_n[0] !== 2'b00 || word_count[0] !== 8'(exp_n)) begin
            errors++;
            $display("FAIL overflow_hold core_rst_n=%b word_count=%0d required 00/%0d", core_rst_n[0], word_count[0], exp_n);
        end
        checks++;
        if (exp_q0.size() != 0) begin
            errors++;
            $display("FAIL overflow_writes missing %0d required 0", exp_q0.size());
        end
    endtask

    task automatic test_exact_fit();
        int got, exp_n, t0, t1;
        bit done, err;
        for (int i = 0; i < 4; i++) pkt[i] = $urandom;
        pulse_start(0);
        checks++;
        if (load_error[0] !== 1'b0 || word_count[0] !== 8'd0) begin
            errors++;
            $display("FAIL error_clear load_error=%b word_count=%0d required 0/0", load_error[0], word_count[0]);
        end
        run_load(0, 4, 1'b1, 1'b0, got, exp_n, done, err);
        wait_release(0, t0, t1);
        cycle();
        checks++;
        if (got !== exp_n || boot_done[0] !== done || load_error[0] !== err || word_count[0] !== 8'(exp_n)) begin
            errors++;
            $display("FAIL exact_fit accepts=%0d boot_done=%b load_error=%b word_count=%0d required %0d/%b/%b/%0d",
                     got, boot_done[0], load_error[0], word_count[0], exp_n, done, err, exp_n);
        end
        checks++;
        if (exp_q0.size() != 0 || core_rst_n[0] !== 2'b11) begin
            errors++;
            $display("FAIL exact_fit_writes missing %0d core_rst_n=%b required 0/11", exp_q0.size(), core_rst_n[0]);
        end
    endtask

    task automatic test_back_to_back_reboot();
        int got, exp_n, t0, t1, n;
        bit done, err;
        n = $urandom_range(2, 8);
        for (int i = 0; i < n; i++) pkt[i] = $urandom;
        pulse_start(1);
        run_load(1, n, 1'b1, 1'b0, got, exp_n, done, err);
        wait_release(1, t0, t1);
        cycle();
        checks++;
        if (got !== exp_n || boot_done[1] !== done || word_count[1] !== 8'(exp_n)) begin
            errors++;
            $display("FAIL b2b_load accepts=%0d boot_done=%b word_count=%0d required %0d/%b/%0d",
                     got, boot_done[1], word_count[1], exp_n, done, exp_n);
        end
        pulse_start(1);
        checks++;
        if (core_rst_n[1] !== 2'b00 || boot_done[1] !== 1'b0) begin
            errors++;
            $display("FAIL reboot_hold core_rst_n=%b boot_done=%b required 00/0", core_rst_n[1], boot_done[1]);
        end
        pkt[0] = $urandom;
        pkt[1] = $urandom;
        run_load(1, 2, 1'b1, 1'b0, got, exp_n, done, err);
        wait_release(1, t0, t1);
        checks++;
        if (t0 < 0 || t1 - t0 != gap(1)) begin
            errors++;
            $display("FAIL reboot_stagger core0 at %0d core1 at %0d required gap %0d", t0, t1, gap(1));
        end
        cycle();
        checks++;
        if (boot_done[1] !== done || word_count[1] !== 8'(exp_n) || exp_q1.size() != 0) begin
            errors++;
            $display("FAIL reboot_status boot_done=%b word_count=%0d missing %0d required %b/%0d/0",
                     boot_done[1], word_count[1], exp_q1.size(), done, exp_n);
        end
    endtask

    task automatic test_async_reset();
        int got, exp_n;
        bit done, err, ok;
        pulse_start(0);
        push_word(0, $urandom, 1'b0, 8, ok);
        checks++;
        if (imem_we[0] !== 1'b1 || core_rst_n[1] !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset imem_we=%b dut1 core_rst_n=%b required 1/11", imem_we[0], core_rst_n[1]);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (imem_we[0] !== 1'b0 || mem_addr[0] !== 32'h0 || mem_wdata[0] !== 32'h0) begin
            errors++;
            $display("FAIL async_write imem_we=%b addr=%h data=%h required 0/0/0", imem_we[0], mem_addr[0], mem_wdata[0]);
        end
        checks++;
        if (core_rst_n[1] !== 2'b00 || boot_done[1] !== 1'b0 || s_ready[0] !== 1'b0 || word_count[0] !== 8'd0) begin
            errors++;
            $display("FAIL async_state core_rst_n=%b boot_done=%b s_ready=%b word_count=%0d required 00/0/0/0",
                     core_rst_n[1], boot_done[1], s_ready[0], word_count[0]);
        end
        repeat (2) cycle();
        rst = 1'b0;
        repeat (2) cycle();
        checks++;
        if (s_ready !== 2'b00 || core_rst_n[0] !== 2'b00 || core_rst_n[1] !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_idle s_ready=%b cores=%b/%b required 00/00/00", s_ready, core_rst_n[0], core_rst_n[1]);
        end
        pkt[0] = $urandom;
        pkt[1] = $urandom;
        pulse_start(0);
        run_load(0, 2, 1'b1, 1'b0, got, exp_n, done, err);
        repeat (2) cycle();
        checks++;
        if (got !== exp_n || exp_q0.size() != 0 || word_count[0] !== 8'(exp_n)) begin
            errors++;
            $display("FAIL post_reset_load accepts=%0d missing %0d word_count=%0d required %0d/0/%0d",
                     got, exp_q0.size(), word_count[0], exp_n, exp_n);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = '0;
        s_valid = '0;
        s_last  = '0;
        s_data  = '0;
        test_reset();
        test_basic_load();
        test_backpressure();
        test_overflow();
        test_exact_fit();
        test_back_to_back_reboot();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule
